gen_vectores_exhaustivo: RTL

//  Synthesisable exhaustive stimulus sequencer for small combinational DUTs.

---
 rtl/gen_vec_pkg.sv | 21 ++
 rtl/misr_16.sv | 35 +++
 rtl/gen_vectores_exhaustivo.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gen_vec_pkg.sv
// Shared definitions for the exhaustive vector sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: sequencer FSM state encoding, MISR polynomial/seed, bin-to-Gray helper.
package gen_vec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seqState_t;

  // x^16 + x^12 + x^5 + 1, x^16 term implicit in the shift-out.
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'h0000;

  function automatic logic [15:0] binToGray(input logic [15:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/misr_16.sv
// 16-bit single-input signature register compacting a serial response stream.
// Latency: sig reflects din one clock after an enabled cycle.
// Backpressure: none; shifts on every cycle en is high.
// Ports:
//   clk  in  1   rising-edge clock
//   rst  in  1   synchronous active-high reset to seed
//   clr  in  1   synchronous clear to seed (wins over en)
//   en   in  1   shift din into the register this cycle
//   din  in  1   serial response bit
//   sig  out 16  current signature
module misr_16
  import gen_vec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] sig
);

  logic feedBack;

  // Input bit joins the bit falling off the top; the sum drives the taps.
  assign feedBack = sig[15] ^ din;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0} ^ ({16{feedBack}} & MISR_POLY);
    end
  end

endmodule

// File: rtl/gen_vectores_exhaustivo.sv
// Exhaustive stimulus sequencer: sweeps all 2**WIDTH codes, each held HOLD_CYCLES clocks, PASSES times.
// Latency: first vector one clock after an accepted start; done one clock after the last valid vector.
// Backpressure: none; start is only sampled in IDLE, ignored while running or finishing.
// Optional feature macro: SIGNATURE_EN adds a 16-bit MISR over resp_in and the signature port.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset, wins over everything
//   start      in   1      begin a run (IDLE only)
//   gray_mode  in   1      0 binary order, 1 Gray order; latched on accepted start
//   resp_in    in   1      DUT response, compacted only when SIGNATURE_EN is defined
//   vec_out    out  WIDTH  registered test vector
//   vec_valid  out  1      vec_out is a live vector
//   busy       out  1      run in progress
//   done       out  1      one-cycle end-of-run pulse
//   signature  out  16     MISR value (SIGNATURE_EN only)
module gen_vectores_exhaustivo
  import gen_vec_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int HOLD_CYCLES = 10,
  parameter int PASSES      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gray_mode,
  input  logic             resp_in,
  output logic [WIDTH-1:0] vec_out,
  output logic             vec_valid,
  output logic             busy,
  output logic             done
`ifdef SIGNATURE_EN
  ,
  output logic [15:0]      signature
`endif
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int PW = $clog2(PASSES + 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0]    PASS_LAST = PW'(PASSES - 1);
  localparam logic [WIDTH-1:0] CODE_LAST = '1;

  seqState_t        state, stateNext;
  logic [WIDTH-1:0] codeCnt, codeNext;
  logic [WIDTH-1:0] vecReg, vecNext;
  logic [HW-1:0]    holdCnt, holdNext;
  logic [PW-1:0]    passCnt, passNext;
  logic             grayMode, grayNext;
  logic             lastHold;

  function automatic logic [WIDTH-1:0] codeToVec(input logic [WIDTH-1:0] code,
                                                 input logic            useGray);
    logic [15:0] wide;
    wide = useGray ? binToGray(16'(code)) : 16'(code);
    return wide[WIDTH-1:0];
  endfunction

  always_comb begin
    stateNext = state;
    codeNext  = codeCnt;
    holdNext  = holdCnt;
    passNext  = passCnt;
    vecNext   = vecReg;
    grayNext  = grayMode;
    lastHold  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = RUN;
          codeNext  = '0;
          holdNext  = '0;
          passNext  = '0;
          grayNext  = gray_mode;
          vecNext   = '0;  // code 0 is 0 in both orders
        end
      end
      RUN: begin
        lastHold = (holdCnt == HOLD_LAST);
        if (lastHold) begin
          holdNext = '0;
          codeNext = codeCnt + WIDTH'(1);
          if (codeCnt == CODE_LAST) begin
            if (passCnt == PASS_LAST) begin
              // Final vector stays on vec_out through FIN and after.
              stateNext = FIN;
            end else begin
              passNext = passCnt + PW'(1);
              vecNext  = codeToVec(codeNext, grayMode);
            end
          end else begin
            vecNext = codeToVec(codeNext, grayMode);
          end
        end else begin
          holdNext = holdCnt + HW'(1);
        end
      end
      FIN: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      codeCnt  <= '0;
      holdCnt  <= '0;
      passCnt  <= '0;
      vecReg   <= '0;
      grayMode <= 1'b0;
    end else begin
      state    <= stateNext;
      codeCnt  <= codeNext;
      holdCnt  <= holdNext;
      passCnt  <= passNext;
      vecReg   <= vecNext;
      grayMode <= grayNext;
    end
  end

  // Status outputs decode the registered state directly, so they are glitch-free.
  assign vec_out   = vecReg;
  assign vec_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == FIN);

`ifdef SIGNATURE_EN
  logic misrClr;

  // Clear on an accepted start; compact one response per vector on its last hold cycle.
  assign misrClr = (state == IDLE) && start;

  misr_16 uMisr (
    .clk (clk),
    .rst (rst),
    .clr (misrClr),
    .en  (lastHold),
    .din (resp_in),
    .sig (signature)
  );
`else
  logic unusedRespIn;
  assign unusedRespIn = resp_in;
`endif

endmodule
